// File: rtl/muldiv_sequencer.sv
// muldiv_sequencer: multi-cycle unsigned MULT/DIV unit with HI/LO result
// registers. One bit per cycle; shift-add multiply, restoring divide.
// The working accumulator {acc_hi, acc_lo} is shared by both ops:
//   MULT: acc_hi = partial product high, acc_lo = multiplier (shifted out)
//   DIV : acc_hi = remainder,            acc_lo = dividend -> quotient
module muldiv_sequencer #(
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = 6
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start_in,
  input  logic                  op_div_in,
  input  logic [DATA_WIDTH-1:0] data_a_in,
  input  logic [DATA_WIDTH-1:0] data_b_in,
  input  logic                  flush_in,
  output logic                  busy_out,
  output logic                  done_out,
  output logic                  error_out,
  output logic [DATA_WIDTH-1:0] lo_out,
  output logic [DATA_WIDTH-1:0] hi_out
);

  localparam int W = DATA_WIDTH;
  localparam logic [CNT_WIDTH-1:0] LAST = CNT_WIDTH'(DATA_WIDTH - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t               r_state, w_next;
  logic [CNT_WIDTH-1:0] r_cnt;
  logic                 r_op_div;
  logic [W-1:0]         r_b;
  logic [W-1:0]         r_acc_hi, r_acc_lo;
  logic [W-1:0]         r_hi, r_lo;
  logic                 r_busy, r_done, r_error;

  // A flush in the same cycle as a start cancels the start.
  logic w_start, w_div0;
  assign w_start = start_in && !flush_in;
  assign w_div0  = op_div_in && (data_b_in == '0);

  // Multiply step: conditional add with carry, then shift right by one.
  logic [W:0]   w_mul_sum;
  logic [W-1:0] w_mul_hi, w_mul_lo;
  assign w_mul_sum = {1'b0, r_acc_hi} + (r_acc_lo[0] ? {1'b0, r_b} : '0);
  assign w_mul_hi  = w_mul_sum[W:1];
  assign w_mul_lo  = {w_mul_sum[0], r_acc_lo[W-1:1]};

  // Restoring divide step: shift in next dividend bit, trial subtract.
  logic [W:0]   w_div_sh, w_div_diff;
  logic         w_div_ge;
  logic [W-1:0] w_div_hi, w_div_lo;
  assign w_div_sh   = {r_acc_hi, r_acc_lo[W-1]};
  assign w_div_diff = w_div_sh - {1'b0, r_b};
  assign w_div_ge   = (w_div_sh >= {1'b0, r_b});
  assign w_div_hi   = w_div_ge ? w_div_diff[W-1:0] : w_div_sh[W-1:0];
  assign w_div_lo   = {r_acc_lo[W-2:0], w_div_ge};

  logic [W-1:0] w_it_hi, w_it_lo;
  assign w_it_hi = r_op_div ? w_div_hi : w_mul_hi;
  assign w_it_lo = r_op_div ? w_div_lo : w_mul_lo;

  // Next-state logic.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (w_start) w_next = w_div0 ? S_DONE : S_RUN;
      S_RUN: begin
        if (flush_in)          w_next = S_IDLE;
        else if (r_cnt == LAST) w_next = S_DONE;
      end
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  // Datapath, HI/LO commit and registered status flags.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cnt    <= '0;
      r_op_div <= 1'b0;
      r_b      <= '0;
      r_acc_hi <= '0;
      r_acc_lo <= '0;
      r_hi     <= '0;
      r_lo     <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_error  <= 1'b0;
    end else begin
      r_busy  <= (w_next == S_RUN);
      r_done  <= 1'b0;
      r_error <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_start) begin
            r_op_div <= op_div_in;
            r_b      <= data_b_in;
            r_acc_hi <= '0;
            r_acc_lo <= data_a_in;
            r_cnt    <= '0;
            if (w_div0) begin
              r_done  <= 1'b1;
              r_error <= 1'b1;
              r_lo    <= '1;
              r_hi    <= data_a_in;
            end
          end
        end
        S_RUN: begin
          // An aborted operation never reaches HI/LO.
          if (!flush_in) begin
            r_acc_hi <= w_it_hi;
            r_acc_lo <= w_it_lo;
            r_cnt    <= r_cnt + 1'b1;
            if (r_cnt == LAST) begin
              r_done <= 1'b1;
              r_hi   <= w_it_hi;
              r_lo   <= w_it_lo;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign busy_out  = r_busy;
  assign done_out  = r_done;
  assign error_out = r_error;
  assign lo_out    = r_lo;
  assign hi_out    = r_hi;

endmodule

// File: doc/muldiv_sequencer.md
Name: muldiv_sequencer

Overview:
- Multi-cycle unsigned multiply/divide unit beside the execute-stage ALU. It takes over R-type MULT and DIV from the single-cycle combinational path.
- Iterates one bit per cycle and stalls the pipeline through a start/busy/done handshake.
- Holds the 2*DATA_WIDTH result in architectural HI/LO registers, read by later instructions.
- Supports pipeline flush (abort) and flags divide-by-zero.

Parameters:
- DATA_WIDTH, 32, operand and HI/LO width.
- CNT_WIDTH, 6, iteration counter width; must satisfy 2^CNT_WIDTH > DATA_WIDTH.

Ports:
- clk  input  1  system clock, all state updates on rising edge.
- rst_n  input  1  synchronous active-low reset; sampled on rising edge of clk.
- start_in  input  1  request pulse from decode/execute control; sampled only in IDLE.
- op_div_in  input  1  0 = MULT, 1 = DIV; sampled with start_in.
- data_a_in  input  DATA_WIDTH  multiplicand / dividend; sampled with start_in.
- data_b_in  input  DATA_WIDTH  multiplier / divisor; sampled with start_in.
- flush_in  input  1  pipeline flush; aborts an operation in progress.
- busy_out  output  1  registered; high while iterating, used as pipeline stall.
- done_out  output  1  registered one-cycle pulse; the result has been written to HI/LO.
- error_out  output  1  registered; high together with done_out when DIV had divisor 0.
- lo_out  output  DATA_WIDTH  LO register: product low half / quotient.
- hi_out  output  DATA_WIDTH  HI register: product high half / remainder.

Behaviour:
- Reset (rst_n=0 at a clock edge):
  - State goes to IDLE.
  - busy_out, done_out and error_out go to 0.
  - lo_out and hi_out go to 0.
  - The counter and working registers are cleared.
  - Reset overrides every other input, including reset asserted mid-operation.
- States: IDLE, RUN, DONE.
- IDLE:
  - If start_in=1 and flush_in=0 at edge T:
    - Latch the operands and the op.
    - Clear the counter.
    - If DIV with data_b_in==0: go to DONE. Otherwise go to RUN with busy_out=1 from T+1.
  - If start_in=1 and flush_in=1 in the same cycle: flush wins, the start is ignored and the state stays IDLE.
- RUN:
  - Exactly DATA_WIDTH iterations, on edges T+1 .. T+DATA_WIDTH.
  - The counter increments each iteration. After the iteration where counter==DATA_WIDTH-1, go to DONE.
  - MULT: shift-add on a 2*DATA_WIDTH accumulator {acc_hi, acc_lo}, with the multiplier in acc_lo.
    - Each cycle: if acc_lo[0]=1, acc_hi += B with DATA_WIDTH+1-bit carry.
    - Then shift the whole accumulator right by 1, with the carry shifting in.
  - DIV: restoring division.
    - Each cycle: remainder = {remainder, quotient MSB}, and quotient shifts left.
    - If remainder >= B: remainder -= B and quotient LSB = 1; otherwise quotient LSB = 0.
  - flush_in=1 in RUN: go to IDLE on the next edge; busy_out=0, no done_out, HI/LO unchanged.
  - start_in is ignored in RUN and DONE; the requester must hold the stall (busy_out).
- DONE (one cycle):
  - Entered normally at T+DATA_WIDTH+1, or at T+1 for divide-by-zero.
  - On entry: HI/LO are written, done_out=1 and busy_out=0.
  - MULT: hi = product[2W-1:W], lo = product[W-1:0].
  - DIV: lo = quotient, hi = remainder.
  - Divide-by-zero: lo = all ones, hi = data_a, error_out=1.
  - Next edge goes to IDLE and clears done_out/error_out.
  - flush_in in DONE has no effect; the result is already committed.
  - A new start is accepted the cycle after DONE, in IDLE.
- Total latency: start edge to done_out high = DATA_WIDTH+1 cycles (33 at default), or 1 cycle for divide-by-zero.
- All arithmetic is unsigned and modular within the stated widths; no signed variants.
- HI/LO hold their value indefinitely between operations and are never written by aborted operations.

Test Plan:
- 7 x 6 MULT:
  - Start at edge T.
  - Required: busy_out=1 for 32 cycles and done_out at T+33.
  - Required: lo_out=42, hi_out=0, error_out=0.
- Full-width MULT, 0xFFFFFFFF x 0xFFFFFFFF:
  - Required: hi_out=0xFFFFFFFE, lo_out=0x00000001 (carry chain check).
- 100 / 7 DIV:
  - Required: lo_out=14, hi_out=2, done_out at T+33.
  - Then 0xFFFFFFFF / 1: required lo_out=0xFFFFFFFF, hi_out=0.
- DIV 5 / 0:
  - Required: done_out and error_out at T+1, busy_out never high.
  - Required: lo_out=0xFFFFFFFF, hi_out=5.
- Flush mid-operation:
  - Complete 7x6 first.
  - Start 9x9, then assert flush_in at iteration 10.
  - Required: IDLE next cycle, no done_out, lo_out stays 42.
  - Start and flush in the same cycle in IDLE: required to be ignored.
- Reset mid-operation:
  - rst_n=0 during RUN: required all outputs 0 after that edge.
  - start_in pulses during RUN: required to be ignored, and the final result matches the first operands.
